// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: widths, opcodes, ALU op encoding and the control bundle.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    alu_src;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'('0);

    function automatic logic is_legal(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
               (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    // Unsupported opcodes fall through to an all-zero bundle.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALU_BRANCH;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN integer register file: two combinational reads, one synchronous write.
// DECODE_WB_BYPASS_EN forwards a same-cycle write-back to the read ports.
module regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_live;

    assign wr_live = wb_en && (wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wb_rd] <= wb_data;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) rs1_val = (wr_live && (wb_rd == rs1)) ? wb_data : regs[rs1];
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) rs2_val = (wr_live && (wb_rd == rs2)) ? wb_data : regs[rs2];
    end
`else
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) rs1_val = regs[rs1];
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) rs2_val = regs[rs2];
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// RV64 decode stage: IF/ID register, register file, decode, ID/EX register and load-use stall.
// DECODE_WB_BYPASS_EN (in regfile) selects same-cycle write-back forwarding.
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            pc_stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_alu_src,
    output logic            id_mem_to_reg,
    output logic [1:0]      id_alu_op,
    output logic            id_illegal
);

    logic            ifid_valid;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            funct7b5;
    logic            legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            load_use;
    ctrl_t           dec_ctrl;
    ctrl_t           id_ctrl;

    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign funct3 = ifid_instr[14:12];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];

    assign legal    = is_legal(opcode);
    assign dec_ctrl = decode_ctrl(opcode);
    assign uses_rs1 = legal;
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD: imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:20]};
            OP_STORE:        imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            OP_BRANCH:       imm = {{(XLEN-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                    ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            default:         imm = '0;
        endcase
    end

    // Only SRAI/SRAW-style shifts carry a meaningful bit 30 among immediate ALU ops.
    always_comb begin
        funct7b5 = 1'b0;
        case (opcode)
            OP_R:    funct7b5 = ifid_instr[30];
            OP_IMM:  funct7b5 = (funct3 == 3'b101) ? ifid_instr[30] : 1'b0;
            default: funct7b5 = 1'b0;
        endcase
    end

    // Purely from IF/ID and ID/EX state, so no path from the if_* inputs.
    assign load_use = id_valid && id_ctrl.mem_read && (id_rd != 5'd0) && ifid_valid &&
                      ((uses_rs1 && (rs1 == id_rd)) || (uses_rs2 && (rs2 == id_rd)));
    assign pc_stall = load_use;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else if (!load_use) begin
            ifid_valid <= if_valid;
            ifid_instr <= if_instr;
            ifid_pc    <= if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || load_use || !ifid_valid) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_rs1_val  <= '0;
            id_rs2_val  <= '0;
            id_imm      <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_rd       <= '0;
            id_funct3   <= '0;
            id_funct7b5 <= 1'b0;
            id_illegal  <= 1'b0;
            id_ctrl     <= CTRL_NOP;
        end else begin
            id_valid    <= 1'b1;
            id_pc       <= ifid_pc;
            id_rs1_val  <= rs1_val;
            id_rs2_val  <= rs2_val;
            id_imm      <= imm;
            id_rs1      <= rs1;
            id_rs2      <= rs2;
            id_rd       <= rd;
            id_funct3   <= funct3;
            id_funct7b5 <= funct7b5;
            id_illegal  <= !legal;
            id_ctrl     <= dec_ctrl;
        end
    end

    assign id_reg_write  = id_ctrl.reg_write;
    assign id_mem_read   = id_ctrl.mem_read;
    assign id_mem_write  = id_ctrl.mem_write;
    assign id_branch     = id_ctrl.branch;
    assign id_alu_src    = id_ctrl.alu_src;
    assign id_mem_to_reg = id_ctrl.mem_to_reg;
    assign id_alu_op     = id_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a cycle-level behavioural model.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        pc_stall, id_valid, id_funct7b5, id_illegal;
    logic [63:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_mem_to_reg;
    logic [1:0]  id_alu_op;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc_stall(pc_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .id_illegal(id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [63:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw, br, as, mtr;
        logic [1:0]  aluop;
        logic        ill, care_imm, care_f7;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mregs [32];
    logic        mf_v;
    logic [31:0] mf_instr;
    logic [63:0] mf_pc;
    exp_t        me;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        bit src1, src2;
        src1 = ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        src2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        return (r != 0) && ((src1 && ins[19:15] == r) || (src2 && ins[24:20] == r));
    endfunction

    function automatic bit stall_now();
        return me.v && me.mr && (me.rd != 0) && mf_v && reads_reg(mf_instr, me.rd);
    endfunction

    // Register read as seen during the current cycle, before the clock edge.
    function automatic logic [63:0] rd_val(input logic [4:0] r);
        if (r == 0) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_rd == r) return wb_data;
`endif
        return mregs[r];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        exp_t   e;
        longint im_i, im_s, im_b;
        e = '0;
        e.v = 1; e.pc = pc;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
        e.rs1v = rd_val(ins[19:15]); e.rs2v = rd_val(ins[24:20]);
        im_i = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:20]);
        im_s = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
        im_b = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        case (ins[6:0])
            7'h33: begin e.rw = 1; e.aluop = 2; e.care_f7 = 1; e.f7 = ins[30]; end
            7'h13: begin
                e.rw = 1; e.as = 1; e.aluop = 2; e.care_imm = 1; e.imm = im_i;
                e.care_f7 = 1; e.f7 = (ins[14:12] == 3'd5) ? ins[30] : 1'b0;
            end
            7'h03: begin e.rw = 1; e.mr = 1; e.mtr = 1; e.as = 1; e.care_imm = 1; e.imm = im_i; end
            7'h23: begin e.mw = 1; e.as = 1; e.care_imm = 1; e.imm = im_s; end
            7'h63: begin e.br = 1; e.aluop = 1; e.care_imm = 1; e.imm = im_b; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic compare_all();
        check("pc_stall", pc_stall, stall_now());
        check("id_valid", id_valid, me.v);
        check("reg_write", id_reg_write, me.rw);
        check("mem_read", id_mem_read, me.mr);
        check("mem_write", id_mem_write, me.mw);
        check("branch", id_branch, me.br);
        check("alu_src", id_alu_src, me.as);
        check("mem_to_reg", id_mem_to_reg, me.mtr);
        check("alu_op", id_alu_op, me.aluop);
        check("illegal", id_illegal, me.ill);
        if (me.v) check("pc", id_pc, me.pc);
        if (me.v && !me.ill) begin
            check("rs1", id_rs1, me.rs1);
            check("rs2", id_rs2, me.rs2);
            check("rd", id_rd, me.rd);
            check("funct3", id_funct3, me.f3);
            check("rs1_val", id_rs1_val, me.rs1v);
            check("rs2_val", id_rs2_val, me.rs2v);
            if (me.care_imm) check("imm", id_imm, me.imm);
            if (me.care_f7) check("funct7b5", id_funct7b5, me.f7);
        end
    endtask

    // One clock: model the edge from the current inputs, then compare after it.
    task automatic tick();
        exp_t        n_me;
        logic        n_v, st, wr;
        logic [31:0] n_i;
        logic [63:0] n_pc;
        st = stall_now();
        if (reset || flush || st || !mf_v) n_me = '0;
        else n_me = ref_decode(mf_instr, mf_pc);
        n_v = mf_v; n_i = mf_instr; n_pc = mf_pc;
        if (reset || flush) begin n_v = 0; n_i = '0; n_pc = '0; end
        else if (!st) begin n_v = if_valid; n_i = if_instr; n_pc = if_pc; end
        wr = !reset && wb_en && (wb_rd != 0);
        @(posedge clk);
        #1;
        me = n_me; mf_v = n_v; mf_instr = n_i; mf_pc = n_pc;
        if (reset) for (int i = 0; i < 32; i++) mregs[i] = '0;
        else if (wr) mregs[wb_rd] = wb_data;
        compare_all();
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic we, input logic [4:0] wr, input logic [63:0] wd);
        reset = 0; if_valid = v; if_instr = ins; if_pc = pc;
        flush = fl; wb_en = we; wb_rd = wr; wb_data = wd;
        tick();
    endtask

    initial begin
        logic [6:0]  ops [9];
        logic [31:0] ins;
        logic [63:0] pc;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h03, 7'h7F, 7'h37, 7'h6F};
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mf_v = 0; mf_instr = '0; mf_pc = '0; me = '0;
        reset = 1; if_valid = 1; if_instr = 32'h00118233; if_pc = 64'h40;
        flush = 0; wb_en = 1; wb_rd = 5'd5; wb_data = 64'h55;
        tick();
        tick();
        check("rst_imm", id_imm, 64'd0);
        check("rst_rd", id_rd, 5'd0);
        check("rst_rs1_val", id_rs1_val, 64'd0);
        check("rst_stall", pc_stall, 1'b0);

        // x5 reads zero after reset
        step(1, 32'h00028333, 64'h80, 0, 0, 0, 0);
        step(0, 32'h0, 64'h0, 0, 0, 0, 0);
        check("x5_after_reset", id_rs1_val, 64'd0);

        // addi x2,x1,-1 with x1 = 0x10
        step(0, 32'h0, 64'h0, 0, 1, 5'd1, 64'h10);
        step(1, 32'hFFF08113, 64'h100, 0, 0, 0, 0);
        step(0, 32'h0, 64'h0, 0, 0, 0, 0);
        check("addi_rs1_val", id_rs1_val, 64'h10);
        check("addi_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_alu_src", id_alu_src, 1'b1);
        check("addi_reg_write", id_reg_write, 1'b1);

        // ld x3,0(x2); add x4,x3,x1 -> one stall, one bubble
        step(1, 32'h00013183, 64'h104, 0, 0, 0, 0);
        step(1, 32'h00118233, 64'h108, 0, 0, 0, 0);
        check("lu_stall", pc_stall, 1'b1);
        step(1, 32'h00118233, 64'h108, 0, 0, 0, 0);
        check("lu_bubble", id_valid, 1'b0);
        check("lu_stall_clears", pc_stall, 1'b0);
        step(0, 32'h0, 64'h0, 0, 0, 0, 0);
        check("lu_add_rs1", id_rs1, 5'd3);
        check("lu_add_valid", id_valid, 1'b1);

        // flush during the stall
        step(1, 32'h00013183, 64'h200, 0, 0, 0, 0);
        step(1, 32'h00118233, 64'h204, 0, 0, 0, 0);
        check("fl_stall", pc_stall, 1'b1);
        step(1, 32'h00118233, 64'h204, 1, 0, 0, 0);
        check("fl_stall_gone", pc_stall, 1'b0);
        check("fl_bubble", id_valid, 1'b0);
        step(0, 32'h0, 64'h0, 0, 0, 0, 0);
        check("fl_ifid_killed", id_valid, 1'b0);

        // illegal opcode, write to x0
        step(1, 32'h0000007F, 64'h300, 0, 1, 5'd0, 64'hDEAD);
        step(1, 32'h000004B3, 64'h304, 0, 0, 0, 0);
        check("ill_flag", id_illegal, 1'b1);
        check("ill_valid", id_valid, 1'b1);
        check("ill_reg_write", id_reg_write, 1'b0);
        step(0, 32'h0, 64'h0, 0, 0, 0, 0);
        check("x0_reads_zero", id_rs1_val, 64'd0);

        // same-cycle write-back of x7 while add x8,x7,x0 is in decode
        step(1, 32'h00038433, 64'h400, 0, 0, 0, 0);
        step(0, 32'h0, 64'h0, 0, 1, 5'd7, 64'hABCD);
`ifdef DECODE_WB_BYPASS_EN
        check("wb_bypass", id_rs1_val, 64'hABCD);
`else
        check("wb_no_bypass", id_rs1_val, 64'd0);
`endif

        pc = 64'h1000;
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_en = ($urandom_range(0, 2) == 0);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            if (!stall_now() || flush || reset) begin
                ins = $urandom;
                ins[6:0] = ops[$urandom_range(0, 8)];
                ins[11:7] = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                if_valid = ($urandom_range(0, 3) != 0);
                if_instr = ins;
                if_pc = pc;
                pc = pc + 4;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
